main_module: RTL and testbench

ATM session controller: card insertion, language selection, PIN verification, then a menu of withdraw, deposit, balance check and exit against one 8-bit account balance. Top-level control block of the ATM design. Single-clock FSM with a balance register. Amounts and selections come from a user-interface front end.

---
 rtl/atm_pkg.sv | 26 ++
 rtl/atm_account.sv | 50 +++++
 rtl/main_module.sv | 150 +++++++++++++++
 tb/tb_main_module.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and default constants for the ATM session controller.
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LANG,
    S_PIN,
    S_MENU,
    S_WITHDRAW,
    S_DEPOSIT,
    S_BALANCE,
    S_HOLD
  } state_e;

  typedef enum logic [1:0] {
    OP_WITHDRAW = 2'd0,
    OP_DEPOSIT  = 2'd1,
    OP_BALANCE  = 2'd2,
    OP_EXIT     = 2'd3
  } op_e;

  localparam logic [3:0]  DEF_PIN_CODE     = 4'b1111;
  localparam logic [7:0]  DEF_INIT_BALANCE = 8'd100;
  localparam int unsigned DEF_MAX_TRIES    = 3;

endpackage

// File: rtl/atm_account.sv
// Account balance register with saturating-free add/subtract:
// requests that would overflow or overdraw are flagged and ignored.
module atm_account
  import atm_pkg::*;
#(
  parameter logic [7:0] INIT_BALANCE = DEF_INIT_BALANCE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wd_en,
  input  logic       i_dep_en,
  input  logic [5:0] i_wd_amt,
  input  logic [5:0] i_dep_amt,
  output logic [7:0] o_balance,
  output logic [7:0] o_wd_balance,
  output logic [7:0] o_dep_balance,
  output logic       o_insufficient,
  output logic       o_overflow
);

  logic [7:0] r_balance;
  logic [7:0] w_wd_ext;
  logic [7:0] w_dep_ext;
  logic [8:0] w_sum;

  // Candidate results and the flags that decide whether they may be applied
  always_comb begin
    w_wd_ext       = {2'b00, i_wd_amt};
    w_dep_ext      = {2'b00, i_dep_amt};
    w_sum          = {1'b0, r_balance} + {1'b0, w_dep_ext};
    o_insufficient = (w_wd_ext > r_balance);
    o_overflow     = w_sum[8];
    o_wd_balance   = r_balance - w_wd_ext;
    o_dep_balance  = w_sum[7:0];
  end

  // Balance register: load on reset, otherwise apply only legal requests
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_balance <= INIT_BALANCE;
    end else if (i_wd_en && !o_insufficient) begin
      r_balance <= o_wd_balance;
    end else if (i_dep_en && !o_overflow) begin
      r_balance <= o_dep_balance;
    end
  end

  assign o_balance = r_balance;

endmodule

// File: rtl/main_module.sv
// ATM session controller: card/language/PIN login, then a menu of
// withdraw, deposit, balance and exit against a single account.
module main_module
  import atm_pkg::*;
#(
  parameter logic [3:0]  PIN_CODE     = DEF_PIN_CODE,
  parameter logic [7:0]  INIT_BALANCE = DEF_INIT_BALANCE,
  parameter int unsigned MAX_TRIES    = DEF_MAX_TRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Insert_card,
  input  logic       Language_chosen,
  input  logic [3:0] Pin,
  input  logic [1:0] Operation,
  input  logic [5:0] Deposit_Amount,
  input  logic [5:0] WithDraw_Amount,
  input  logic       exit,
  input  logic       home_in,
  output logic [7:0] Check_balance,
  output logic [7:0] FinalBalance
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  state_e           r_state;
  op_e              r_exec_op;
  logic [TRY_W-1:0] r_tries;
  logic [3:0]       r_prev_pin;
  logic [7:0]       r_final;

  logic       w_abort;
  logic       w_wd_en;
  logic       w_dep_en;
  logic [7:0] w_balance;
  logic [7:0] w_wd_balance;
  logic [7:0] w_dep_balance;
  logic       w_insufficient;
  logic       w_overflow;

  // Account requests are only issued when no higher-priority exit/home wins
  always_comb begin
    w_abort  = exit || (Operation == OP_EXIT);
    w_wd_en  = (r_state == S_WITHDRAW) && !w_abort && !home_in &&
               (WithDraw_Amount != '0);
    w_dep_en = (r_state == S_DEPOSIT) && !w_abort && !home_in &&
               (Deposit_Amount != '0);
  end

  atm_account #(
    .INIT_BALANCE (INIT_BALANCE)
  ) u_account (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wd_en        (w_wd_en),
    .i_dep_en       (w_dep_en),
    .i_wd_amt       (WithDraw_Amount),
    .i_dep_amt      (Deposit_Amount),
    .o_balance      (w_balance),
    .o_wd_balance   (w_wd_balance),
    .o_dep_balance  (w_dep_balance),
    .o_insufficient (w_insufficient),
    .o_overflow     (w_overflow)
  );

  // Session FSM, PIN-try counter and latched final balance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_exec_op  <= OP_WITHDRAW;
      r_tries    <= '0;
      r_prev_pin <= '0;
      r_final    <= '0;
    end else begin
      r_prev_pin <= Pin;
      case (r_state)
        S_IDLE: begin
          if (Insert_card) r_state <= S_LANG;
        end
        S_LANG: begin
          if (exit) r_state <= S_IDLE;
          else if (Language_chosen) r_state <= S_PIN;
        end
        S_PIN: begin
          if (exit) begin
            r_state <= S_IDLE;
            r_tries <= '0;
          end else if (Pin == PIN_CODE) begin
            r_state <= S_MENU;
            r_tries <= '0;
          end else if (Pin != r_prev_pin) begin
            if (r_tries == TRY_LAST) begin
              r_state <= S_IDLE;
              r_tries <= '0;
            end else begin
              r_tries <= r_tries + 1'b1;
            end
          end
        end
        default: begin
          // Balance view refreshes every cycle it is shown
          if (r_state == S_BALANCE) r_final <= w_balance;
          if (w_abort) begin
            r_state <= S_IDLE;
            r_final <= w_balance;
          end else if (home_in) begin
            r_state <= S_MENU;
          end else begin
            case (r_state)
              S_MENU: begin
                case (Operation)
                  OP_WITHDRAW: r_state <= S_WITHDRAW;
                  OP_DEPOSIT:  r_state <= S_DEPOSIT;
                  OP_BALANCE:  r_state <= S_BALANCE;
                  default:     r_state <= S_MENU;
                endcase
              end
              S_WITHDRAW: begin
                if (WithDraw_Amount != '0 && !w_insufficient) begin
                  r_final   <= w_wd_balance;
                  r_exec_op <= OP_WITHDRAW;
                  r_state   <= S_HOLD;
                end
              end
              S_DEPOSIT: begin
                if (Deposit_Amount != '0) begin
                  if (!w_overflow) r_final <= w_dep_balance;
                  r_exec_op <= OP_DEPOSIT;
                  r_state   <= S_HOLD;
                end
              end
              S_BALANCE: begin
                if (Operation != OP_BALANCE) r_state <= S_MENU;
              end
              S_HOLD: begin
                if (Operation != r_exec_op) r_state <= S_MENU;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign Check_balance = w_balance;
  assign FinalBalance  = r_final;

endmodule

// File: tb/tb_main_module.sv
// Self-checking bench for the ATM session controller: directed scenarios
// plus randomized traffic against a behavioural session model.
module tb_main_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       Insert_card;
  logic       Language_chosen;
  logic [3:0] Pin;
  logic [1:0] Operation;
  logic [5:0] Deposit_Amount;
  logic [5:0] WithDraw_Amount;
  logic       exit;
  logic       home_in;
  logic [7:0] Check_balance;
  logic [7:0] FinalBalance;

  int errors = 0;
  int checks = 0;

  main_module dut (
    .clk             (clk),
    .rst             (rst),
    .Insert_card     (Insert_card),
    .Language_chosen (Language_chosen),
    .Pin             (Pin),
    .Operation       (Operation),
    .Deposit_Amount  (Deposit_Amount),
    .WithDraw_Amount (WithDraw_Amount),
    .exit            (exit),
    .home_in         (home_in),
    .Check_balance   (Check_balance),
    .FinalBalance    (FinalBalance)
  );

  always #5 clk = ~clk;

  // Behavioural session model (mode names follow the session description)
  localparam int M_IDLE = 0, M_LANG = 1, M_PIN = 2, M_MENU = 3;
  localparam int M_WD = 4, M_DEP = 5, M_BAL = 6, M_HOLD = 7;
  int m_mode, m_bal, m_fb, m_tries, m_prev, m_exec;

  task automatic model_step();
    int a;
    if (rst) begin
      m_mode = M_IDLE; m_bal = 100; m_fb = 0; m_tries = 0; m_prev = 0; m_exec = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (Insert_card) m_mode = M_LANG;
      M_LANG: begin
        if (exit) m_mode = M_IDLE;
        else if (Language_chosen) m_mode = M_PIN;
      end
      M_PIN: begin
        if (exit) begin m_mode = M_IDLE; m_tries = 0; end
        else if (int'(Pin) == 15) begin m_mode = M_MENU; m_tries = 0; end
        else if (int'(Pin) != m_prev) begin
          m_tries++;
          if (m_tries >= 3) begin m_mode = M_IDLE; m_tries = 0; end
        end
      end
      default: begin
        if (m_mode == M_BAL) m_fb = m_bal;
        if (exit || Operation == 2'd3) begin
          m_fb = m_bal; m_mode = M_IDLE;
        end else if (home_in) begin
          m_mode = M_MENU;
        end else if (m_mode == M_MENU) begin
          m_mode = (Operation == 2'd0) ? M_WD : (Operation == 2'd1) ? M_DEP : M_BAL;
        end else if (m_mode == M_WD) begin
          a = int'(WithDraw_Amount);
          if (a != 0 && a <= m_bal) begin
            m_bal -= a; m_fb = m_bal; m_exec = 0; m_mode = M_HOLD;
          end
        end else if (m_mode == M_DEP) begin
          a = int'(Deposit_Amount);
          if (a != 0) begin
            if (m_bal + a <= 255) begin m_bal += a; m_fb = m_bal; end
            m_exec = 1; m_mode = M_HOLD;
          end
        end else if (m_mode == M_BAL) begin
          if (Operation != 2'd2) m_mode = M_MENU;
        end else begin
          if (int'(Operation) != m_exec) m_mode = M_MENU;
        end
      end
    endcase
    m_prev = int'(Pin);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Insert_card = 0; Language_chosen = 0; Pin = 0; Operation = 0;
    Deposit_Amount = 0; WithDraw_Amount = 0; exit = 0; home_in = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic login(input logic [1:0] op);
    Insert_card = 1; Language_chosen = 1; Pin = 4'b1111; Operation = op;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (Check_balance !== 8'd100) begin
      errors++; $display("FAIL reset_balance: got %0d want 100", Check_balance);
    end
    checks++;
    if (FinalBalance !== 8'd0) begin
      errors++; $display("FAIL reset_final: got %0d want 0", FinalBalance);
    end
  endtask

  task automatic test_deposit();
    do_reset();
    Deposit_Amount = 10;
    login(2'd1);
    tick();  // MENU -> DEPOSIT
    checks++;
    if (Check_balance !== 8'd100) begin
      errors++; $display("FAIL dep_latency: got %0d want 100", Check_balance);
    end
    tick();
    checks++;
    if (Check_balance !== 8'd110 || FinalBalance !== 8'd110) begin
      errors++;
      $display("FAIL dep_10: got %0d/%0d want 110/110", Check_balance, FinalBalance);
    end
    Operation = 2'd2;
    repeat (4) tick();
    checks++;
    if (Check_balance !== 8'd110 || FinalBalance !== 8'd110) begin
      errors++;
      $display("FAIL dep_balance_view: got %0d/%0d want 110/110", Check_balance, FinalBalance);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    WithDraw_Amount = 20;
    login(2'd0);
    repeat (2) tick();
    checks++;
    if (Check_balance !== 8'd80 || FinalBalance !== 8'd80) begin
      errors++;
      $display("FAIL wd_20: got %0d/%0d want 80/80", Check_balance, FinalBalance);
    end
    Operation = 2'd3; WithDraw_Amount = 0; Insert_card = 0;
    tick();
    Operation = 2'd1; Deposit_Amount = 5;
    repeat (4) tick();
    checks++;
    if (Check_balance !== 8'd80 || FinalBalance !== 8'd80) begin
      errors++;
      $display("FAIL wd_exit_idle: got %0d/%0d want 80/80", Check_balance, FinalBalance);
    end
  endtask

  task automatic test_withdraw_reject();
    do_reset();
    WithDraw_Amount = 63;
    login(2'd0);
    repeat (2) tick();
    checks++;
    if (Check_balance !== 8'd37) begin
      errors++; $display("FAIL wd_63: got %0d want 37", Check_balance);
    end
    home_in = 1; tick();
    home_in = 0; tick();  // MENU -> WITHDRAW
    repeat (2) tick();    // 63 > 37: rejected, stays
    checks++;
    if (Check_balance !== 8'd37 || FinalBalance !== 8'd37) begin
      errors++;
      $display("FAIL wd_reject: got %0d/%0d want 37/37", Check_balance, FinalBalance);
    end
    WithDraw_Amount = 30; tick();
    checks++;
    if (Check_balance !== 8'd7 || FinalBalance !== 8'd7) begin
      errors++;
      $display("FAIL wd_30_after_reject: got %0d/%0d want 7/7", Check_balance, FinalBalance);
    end
    home_in = 1; tick();
    home_in = 0; WithDraw_Amount = 0; tick();  // back in WITHDRAW
    WithDraw_Amount = 5; home_in = 1; tick();  // home wins, no debit
    home_in = 0; WithDraw_Amount = 0; Operation = 2'd2; tick();
    checks++;
    if (Check_balance !== 8'd7 || FinalBalance !== 8'd7) begin
      errors++;
      $display("FAIL wd_home: got %0d/%0d want 7/7", Check_balance, FinalBalance);
    end
  endtask

  task automatic test_wrong_pin();
    do_reset();
    Insert_card = 1; Language_chosen = 1; Pin = 0;
    repeat (2) tick();  // now in PIN
    Insert_card = 0;
    Pin = 1; tick();
    Pin = 2; tick();
    Pin = 3; tick();
    Pin = 4'b1111; Operation = 2'd1; Deposit_Amount = 10;
    repeat (4) tick();
    checks++;
    if (Check_balance !== 8'd100 || FinalBalance !== 8'd0) begin
      errors++;
      $display("FAIL pin_reject: got %0d/%0d want 100/0", Check_balance, FinalBalance);
    end
    // A held wrong PIN counts once; two attempts then the right PIN logs in
    do_reset();
    Insert_card = 1; Language_chosen = 1; Pin = 0; Operation = 2'd1; Deposit_Amount = 4;
    repeat (2) tick();
    Pin = 1; repeat (2) tick();
    Pin = 2; tick();
    Pin = 4'b1111; tick();  // -> MENU
    repeat (2) tick();      // -> DEPOSIT, apply
    checks++;
    if (Check_balance !== 8'd104 || FinalBalance !== 8'd104) begin
      errors++;
      $display("FAIL pin_held_wrong: got %0d/%0d want 104/104", Check_balance, FinalBalance);
    end
  endtask

  task automatic test_overflow();
    int exp_bal[3] = '{163, 226, 226};
    do_reset();
    Deposit_Amount = 63;
    login(2'd1);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) tick();
      else begin
        home_in = 1; tick();
        home_in = 0; tick();
      end
      tick();
      checks++;
      if (Check_balance !== 8'(exp_bal[k]) || FinalBalance !== 8'(exp_bal[k])) begin
        errors++;
        $display("FAIL dep_overflow_%0d: got %0d/%0d want %0d", k, Check_balance,
                 FinalBalance, exp_bal[k]);
      end
    end
    repeat (3) tick();  // HOLD applies once only
    checks++;
    if (Check_balance !== 8'd226) begin
      errors++; $display("FAIL hold_once: got %0d want 226", Check_balance);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Deposit_Amount = 7;
    login(2'd1);
    repeat (2) tick();  // 107, HOLD
    home_in = 1; tick();
    home_in = 0; Deposit_Amount = 0; tick();  // DEPOSIT, waiting
    rst = 1; #2; rst = 0;                      // pulse between edges
    tick();
    checks++;
    if (Check_balance !== 8'd107 || FinalBalance !== 8'd107) begin
      errors++;
      $display("FAIL zero_width_rst: got %0d/%0d want 107/107", Check_balance, FinalBalance);
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if (Check_balance !== 8'd100 || FinalBalance !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst: got %0d/%0d want 100/0", Check_balance, FinalBalance);
    end
    Insert_card = 0; Deposit_Amount = 9;
    repeat (3) tick();
    checks++;
    if (Check_balance !== 8'd100) begin
      errors++; $display("FAIL mid_rst_idle: got %0d want 100", Check_balance);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1;
    model_step();
    tick();
    rst = 0;
    for (int n = 0; n < 800; n++) begin
      rst             = ($urandom_range(0, 199) == 0);
      Insert_card     = ($urandom_range(0, 3) != 0);
      Language_chosen = $urandom_range(0, 1);
      Pin             = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      Operation       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) Operation = 2'd1;
      Deposit_Amount  = ($urandom_range(0, 9) < 3) ? 6'd0 : 6'($urandom_range(1, 63));
      WithDraw_Amount = ($urandom_range(0, 9) < 3) ? 6'd0 : 6'($urandom_range(1, 63));
      exit            = ($urandom_range(0, 24) == 0);
      home_in         = ($urandom_range(0, 7) == 0);
      model_step();
      tick();
      checks++;
      if (Check_balance !== 8'(m_bal) || FinalBalance !== 8'(m_fb)) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %0d/%0d want %0d/%0d", n, Check_balance,
                 FinalBalance, m_bal, m_fb);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_deposit();
    test_withdraw();
    test_withdraw_reject();
    test_wrong_pin();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
